// File: rtl/clk_div_gen.sv
// Purpose : programmable clock-level divider (IDLE/HIGH/LOW) with ratio handshake and phase ticks.
// Latency : clk_out/tick_rise one cycle after en is sampled; div_ack/div_err one cycle after div_load.
// Backpressure: none; every div_load is accepted or rejected the following cycle, never stalled.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      synchronous active-low reset
//   en         run request; when it drops, the current period completes before IDLE
//   div_in     requested divide ratio (legal >= 2), qualified by div_load
//   div_load   single-cycle strobe for div_in
//   div_ack    pulse: div_in accepted into the pending register
//   div_err    pulse: div_in rejected (ratio < 2), pending state untouched
//   clk_out    registered divided clock level, 1 only in HIGH
//   tick_rise  pulse on the first HIGH cycle of each period
//   tick_fall  pulse on the first LOW cycle after a HIGH phase
//   pending    an accepted ratio is waiting for the next period boundary
//   sync       (only with CLK_DIV_SYNC_EN) force a period boundary from HIGH or LOW
//
// Optional feature macro: CLK_DIV_SYNC_EN adds the sync input.
module clk_div_gen #(
    parameter int CNT_W     = 8,
    parameter int RESET_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick_rise;
    logic             r_tick_fall;
    logic             r_ack;
    logic             r_err;

    logic             w_boundary;
    logic             w_fall;
    logic             w_sync;
    logic             w_ld_ok;
    logic [CNT_W-1:0] w_high_len;
    logic [CNT_W-1:0] w_low_len;
    logic             w_last_high;
    logic             w_last_low;

`ifdef CLK_DIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // HIGH gets the odd cycle: ceil(D/2) computed without a carry bit.
    assign w_high_len  = (r_div >> 1) + {{(CNT_W-1){1'b0}}, r_div[0]};
    assign w_low_len   = r_div >> 1;
    assign w_last_high = (r_cnt == (w_high_len - CNT_W'(1)));
    assign w_last_low  = (r_cnt == (w_low_len - CNT_W'(1)));
    assign w_ld_ok     = div_load && (div_in >= CNT_W'(2));

    // Next-state / phase-counter logic. The counter restarts at every phase
    // change, so it only ever counts up to phase length - 1 and cannot wrap.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + CNT_W'(1);
        w_boundary  = 1'b0;
        w_fall      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_nxt_cnt = '0;
                if (en) begin
                    w_nxt_state = ST_HIGH;
                    w_boundary  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_last_high) begin
                    w_nxt_state = ST_LOW;
                    w_nxt_cnt   = '0;
                    w_fall      = 1'b1;
                end
            end
            ST_LOW: begin
                // en is only consulted at the period end, so a dropped en
                // always lets the running period finish, and a restored en
                // keeps the divider running without visiting IDLE.
                if (w_last_low) begin
                    w_nxt_cnt = '0;
                    if (en) begin
                        w_nxt_state = ST_HIGH;
                        w_boundary  = 1'b1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase

        // A sync from a running state overrides everything, including an
        // en=0 period completion in the same cycle.
        if (w_sync && (r_state != ST_IDLE)) begin
            w_nxt_state = ST_HIGH;
            w_nxt_cnt   = '0;
            w_boundary  = 1'b1;
            w_fall      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_div       <= CNT_W'(RESET_DIV);
            r_pend_div  <= '0;
            r_pending   <= 1'b0;
            r_clk_out   <= 1'b0;
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_clk_out   <= (w_nxt_state == ST_HIGH);
            r_tick_rise <= w_boundary;
            r_tick_fall <= w_fall;
            r_ack       <= w_ld_ok;
            r_err       <= div_load && !w_ld_ok;

            // The boundary consumes the value that was pending before this
            // cycle; a load landing on the same cycle stays pending for the
            // next boundary.
            if (w_boundary && r_pending) begin
                r_div <= r_pend_div;
            end

            if (w_ld_ok) begin
                r_pend_div <= div_in;
                r_pending  <= 1'b1;
            end else if (w_boundary) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign clk_out   = r_clk_out;
    assign tick_rise = r_tick_rise;
    assign tick_fall = r_tick_fall;
    assign div_ack   = r_ack;
    assign div_err   = r_err;
    assign pending   = r_pending;

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       div_load;
    logic [7:0] div_in;
`ifdef CLK_DIV_SYNC_EN
    logic       sync;
`endif
    logic       div_ack;
    logic       div_err;
    logic       clk_out;
    logic       tick_rise;
    logic       tick_fall;
    logic       pending;

    always #5 clk = ~clk;

    clk_div_gen #(
        .CNT_W     (8),
        .RESET_DIV (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .div_load  (div_load),
`ifdef CLK_DIV_SYNC_EN
        .sync      (sync),
`endif
        .div_ack   (div_ack),
        .div_err   (div_err),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .pending   (pending)
    );

    typedef struct packed {
        logic clk_out;
        logic tick_rise;
        logic tick_fall;
        logic div_ack;
        logic div_err;
        logic pending;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       ld;
        logic [7:0] din;
        exp_t       x;
    } vec_t;

    exp_t  exp_q[$];
    vec_t  tbl[6];
    int    n_vec = 0;
    int    n_err = 0;
    logic  exp_pend;
    string tag;
    int    step;

    // Pop the expectation pushed when the stimulus was driven and compare it
    // with what the DUT shows after the clock edge.
    task automatic check();
        exp_t got;
        exp_t want;
        got = {clk_out, tick_rise, tick_fall, div_ack, div_err, pending};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s step %0d: scoreboard empty, got %b", tag, step, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL %s step %0d: got %b want %b (clk_out,tick_rise,tick_fall,div_ack,div_err,pending)",
                         tag, step, got, want);
            end
        end
    endtask

    // One clock: drive inputs (we sit on a falling edge), record the expected
    // post-edge outputs, then compare on the next falling edge.
    task automatic cyc(input logic r, input logic e, input logic ld,
                       input logic [7:0] v, input exp_t x);
        rst_n    = r;
        en       = e;
        div_load = ld;
        div_in   = ld ? v : 8'($urandom_range(0, 255));
        exp_q.push_back(x);
        @(negedge clk);
        check();
    endtask

    task automatic idle(input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            step = i;
            x = '0;
            x.pending = exp_pend;
            cyc(1'b1, 1'b0, 1'b0, 8'd0, x);
        end
    endtask

    // Steps first..n-1 of a period of ratio d. Step 0 is the period boundary
    // (first HIGH cycle). en is low for steps en_a..en_b; up to two loads.
    task automatic period(input int d, input int n, input int first,
                          input int en_a, input int en_b,
                          input int l1s, input logic [7:0] l1v,
                          input int l2s, input logic [7:0] l2v);
        int         hi;
        exp_t       x;
        logic       ld;
        logic       ok;
        logic       e;
        logic [7:0] v;
        hi = (d + 1) / 2;
        for (int i = first; i < n; i++) begin
            step = i;
            ld = (i == l1s) || (i == l2s);
            v  = (i == l1s) ? l1v : l2v;
            ok = ld && (v >= 8'd2);
            e  = !((i >= en_a) && (i <= en_b));
            if (i == 0) exp_pend = ok;
            else if (ok) exp_pend = 1'b1;
            x.clk_out   = (i < hi);
            x.tick_rise = (i == 0);
            x.tick_fall = (i == hi);
            x.div_ack   = ok;
            x.div_err   = ld && !ok;
            x.pending   = exp_pend;
            cyc(1'b1, e, ld, v, x);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = 8'd0;
`ifdef CLK_DIV_SYNC_EN
        sync     = 1'b0;
`endif
        exp_pend = 1'b0;

        // Reset and IDLE behaviour, rejected loads. Field order of x:
        // clk_out, tick_rise, tick_fall, div_ack, div_err, pending.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b000000};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'd5, 6'b000000};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'd0, 6'b000000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'd1, 6'b000010};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'd0, 6'b000010};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'd0, 6'b000000};
        tag = "reset_table";
        for (int i = 0; i < 6; i++) begin
            step = i;
            cyc(tbl[i].rst_n, tbl[i].en, tbl[i].ld, tbl[i].din, tbl[i].x);
        end
        exp_pend = 1'b0;

        tag = "div8_first";   period(8, 8, 0, -1, -1, -1, 8'd0, -1, 8'd0);
        tag = "div8_load5";   period(8, 8, 0, -1, -1,  2, 8'd5,  4, 8'd1);
        tag = "div5_err0";    period(5, 5, 0, -1, -1, -1, 8'd0,  1, 8'd0);
        tag = "div5_ld3_10";  period(5, 5, 0, -1, -1,  3, 8'd3,  4, 8'd10);
        tag = "div10_bndld6"; period(10, 10, 0, -1, -1, 0, 8'd6, -1, 8'd0);
        tag = "div6_en_drop"; period(6, 6, 0, 1, 5, -1, 8'd0, -1, 8'd0);
        tag = "idle_after";   idle(4);
        tag = "div6_en_blip"; period(6, 6, 0, 1, 2, -1, 8'd0, -1, 8'd0);
        tag = "div6_partial"; period(6, 5, 0, -1, -1, 1, 8'd2, -1, 8'd0);

        tag = "reset_midlow";
        step = 0;
        exp_pend = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 6'b000000);
        tag = "div8_postrst"; period(8, 8, 0, -1, -1, -1, 8'd0, -1, 8'd0);

`ifdef CLK_DIV_SYNC_EN
        tag = "div8_presync"; period(8, 6, 0, -1, -1, -1, 8'd0, -1, 8'd0);
        tag = "sync_midlow";
        step = 0;
        sync = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 6'b110000);
        sync = 1'b0;
        tag = "div8_synced";  period(8, 8, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        tag = "sync_over_en";
        step = 0;
        sync = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 6'b110000);
        sync = 1'b0;
        tag = "div8_after";   period(8, 8, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        tag = "idle_end";     idle(2);
        tag = "sync_in_idle";
        sync = 1'b1;
        idle(1);
        sync = 1'b0;
`else
        tag = "idle_end";     idle(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the divide ratio and the phase counter.
REQ-002 SHALL have parameter RESET_DIV, default 8, giving the divide ratio loaded at reset; legal range is 2..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  run request for the divided output.
REQ-006 SHALL have port div_in  input  CNT_W  requested divide ratio.
REQ-007 SHALL have port div_load  input  1  single-cycle strobe qualifying div_in.
REQ-008 SHALL have port div_ack  output  1  single-cycle pulse: div_in accepted.
REQ-009 SHALL have port div_err  output  1  single-cycle pulse: div_in rejected.
REQ-010 SHALL have port clk_out  output  1  registered divided clock-level signal.
REQ-011 SHALL have port tick_rise  output  1  single-cycle pulse on the first cycle clk_out is 1.
REQ-012 SHALL have port tick_fall  output  1  single-cycle pulse on the first cycle clk_out is 0 after a high phase.
REQ-013 SHALL have port pending  output  1  an accepted ratio is waiting to be applied.

Function
REQ-014 SHALL implement the states IDLE, HIGH and LOW; clk_out SHALL be 1 only in HIGH.
REQ-015 SHALL, for active ratio D: HIGH lasts ceil(D/2) cycles, LOW lasts floor(D/2) cycles, period exactly D cycles.
REQ-016 SHALL go IDLE->HIGH one cycle after en is sampled 1, with clk_out=1 and tick_rise=1 together.
REQ-017 SHALL go HIGH->LOW after ceil(D/2) cycles with tick_fall=1, and LOW->HIGH after floor(D/2) cycles with tick_rise=1.
REQ-018 SHALL, when en is sampled 0 in HIGH or LOW, complete the current period, then enter IDLE instead of HIGH; no truncated phase.
REQ-019 SHALL continue running without passing through IDLE if en returns to 1 before the period completes.
REQ-020 SHALL, on div_load with div_in>=2, store div_in in a pending register, set pending, and pulse div_ack on the following cycle.
REQ-021 SHALL, on div_load with div_in<2, leave the pending register and flag unchanged and pulse div_err on the following cycle.
REQ-022 SHALL apply the pending ratio only at a period boundary (entry to HIGH from LOW or IDLE), then clear pending.
REQ-023 SHALL make the last accepted load win when a second load arrives while pending.
REQ-024 SHALL, on a load in the same cycle as a boundary, consume the old pending value at that boundary; the new value stays pending for the next one.
REQ-025 SHALL make the phase counter saturate-free: the counter resets at each phase change and never wraps within a phase.

Reset
REQ-026 SHALL, while rst_n is sampled 0: state=IDLE, counter=0, clk_out=0, tick_rise=0, tick_fall=0, div_ack=0, div_err=0, pending=0, active ratio=RESET_DIV.
REQ-027 SHALL let reset mid-period abort the period immediately, with no completion of the phase.
REQ-028 SHALL, after rst_n is sampled 1 with en=1, produce the first tick_rise one cycle later.

Configuration
REQ-029 SHALL, with CLK_DIV_SYNC_EN defined, add input sync (1 bit); sync sampled 1 in HIGH or LOW forces a boundary next cycle: HIGH, counter restarted, tick_rise=1, pending applied.
REQ-030 SHALL, with CLK_DIV_SYNC_EN defined, ignore sync in IDLE, and let sync take precedence over en=0 completion for that cycle only.
REQ-031 SHALL, without CLK_DIV_SYNC_EN, omit the sync port and keep all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, en=1, default RESET_DIV=8 -> clk_out 4 high / 4 low, tick_rise every 8 cycles, first one cycle after en.
REQ-033 SHALL cover: load div_in=5 mid-HIGH -> div_ack next cycle, pending=1 until the next boundary, then 3 high / 2 low.
REQ-034 SHALL cover: load div_in=1 and div_in=0 -> div_err pulses, ratio unchanged, pending unaffected.
REQ-035 SHALL cover: en dropped 1 cycle into HIGH at D=6 -> full 3 high / 3 low, then IDLE with clk_out=0 and no further ticks.
REQ-036 SHALL cover: load 3 then 10 before the boundary -> 10 applied; load coinciding with the boundary -> applied one period later.
REQ-037 SHALL cover: rst_n=0 mid-LOW -> all outputs 0 next cycle, ratio back to 8; with CLK_DIV_SYNC_EN, sync mid-LOW -> tick_rise next cycle.
